// File: rtl/r5p_soc_ctrl.sv
// Simulation/test controller on the r5p data bus: signature bounds, halt/exit code,
// cycle counter with timeout, and a console byte FIFO drained through a stream port.
module r5p_soc_ctrl #(
    parameter int unsigned AW      = 22,
    parameter int unsigned DW      = 32,
    parameter int unsigned TMO_RST = 1_000_000,
    parameter int unsigned CW      = 64,
    parameter int unsigned FD      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_vld,
    input  logic            bus_wen,
    input  logic [AW-1:0]   bus_adr,
    input  logic [DW/8-1:0] bus_ben,
    input  logic [DW-1:0]   bus_wdt,
    output logic [DW-1:0]   bus_rdt,
    output logic            bus_rdy,
    output logic [DW-1:0]   sig_begin,
    output logic [DW-1:0]   sig_end,
    output logic            halt,
    output logic            timeout,
    output logic [7:0]      exit_code,
    output logic            con_vld,
    output logic [7:0]      con_dat,
    input  logic            con_rdy,
    output logic            done
);
    localparam int unsigned DBW = DW / 8;
    localparam int unsigned PW  = $clog2(FD);

    localparam logic [5:0] AdrSigBegin = 6'h00;
    localparam logic [5:0] AdrSigEnd   = 6'h08;
    localparam logic [5:0] AdrHalt     = 6'h10;
    localparam logic [5:0] AdrConsole  = 6'h18;
    localparam logic [5:0] AdrTimeout  = 6'h20;
    localparam logic [5:0] AdrCycle    = 6'h28;
    localparam logic [5:0] AdrStatus   = 6'h30;

    typedef enum logic [1:0] {StRun, StHalt, StTmo} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] sig_begin_q, sig_end_q, tmo_q, rdt_q;
    logic [7:0]    exit_code_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic [7:0]    fifo_mem [FD];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   fifo_cnt_q;

    logic [5:0]    adr;
    logic          fifo_full, fifo_empty, pop, push, rdy, wr, rd, halt_req, tmo_hit;
    logic [CW-1:0] limit;
    logic [DW-1:0] wmask, rdata;
    logic          unused_adr;

    assign adr        = bus_adr[5:0];
    assign unused_adr = ^bus_adr[AW-1:6];
    assign fifo_full  = fifo_cnt_q == (PW+1)'(FD);
    assign fifo_empty = fifo_cnt_q == '0;
    assign pop        = !fifo_empty && con_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO need not stall then.
    assign rdy        = !(bus_vld && bus_wen && adr == AdrConsole && fifo_full && !pop);
    assign wr         = bus_vld && rdy && bus_wen;
    assign rd         = bus_vld && rdy && !bus_wen;
    assign push       = wr && adr == AdrConsole && bus_ben[0];
    assign halt_req   = wr && adr == AdrHalt && state_q == StRun;
    assign limit      = CW'(tmo_q);
    assign tmo_hit    = (limit != '0) && (cnt_q == limit - CW'(1));

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DBW; i++) begin
            wmask[8*i +: 8] = {8{bus_ben[i]}};
        end
    end

    always_comb begin
        rdata = '0;
        case (adr)
            AdrSigBegin: rdata = sig_begin_q;
            AdrSigEnd:   rdata = sig_end_q;
            AdrTimeout:  rdata = tmo_q;
            AdrCycle:    rdata = cnt_q[DW-1:0];
            AdrStatus: begin
                rdata[0]    = state_q == StHalt;
                rdata[1]    = state_q == StTmo;
                rdata[2]    = fifo_full;
                rdata[3]    = fifo_empty;
                rdata[15:8] = 8'(fifo_cnt_q);
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt beats a timeout that falls on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (tmo_hit) begin
                    state_d = StTmo;
                end
            end
            StHalt:  state_d = StHalt;
            StTmo:   state_d = StTmo;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        halt    = state_q == StHalt;
        timeout = state_q == StTmo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_begin_q <= '0;
            sig_end_q   <= '0;
            tmo_q       <= DW'(TMO_RST);
            exit_code_q <= '0;
            cnt_q       <= '0;
            rdt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            if (wr && adr == AdrSigBegin) sig_begin_q <= (sig_begin_q & ~wmask) | (bus_wdt & wmask);
            if (wr && adr == AdrSigEnd)   sig_end_q   <= (sig_end_q & ~wmask) | (bus_wdt & wmask);
            if (wr && adr == AdrTimeout)  tmo_q       <= (tmo_q & ~wmask) | (bus_wdt & wmask);
            if (halt_req)                 exit_code_q <= bus_wdt[7:0];
            if (state_q == StRun)         cnt_q       <= cnt_q + CW'(1);
            if (rd)                       rdt_q       <= rdata;
            done_q <= done_q || (state_q != StRun && fifo_empty);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            fifo_cnt_q <= fifo_cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus_wdt[7:0];
    end

    assign bus_rdt   = rdt_q;
    assign bus_rdy   = rdy;
    assign sig_begin = sig_begin_q;
    assign sig_end   = sig_end_q;
    assign exit_code = exit_code_q;
    assign con_vld   = !fifo_empty;
    assign con_dat   = fifo_mem[rd_ptr_q];
    assign done      = done_q;

endmodule
